// File: rtl/cla8_share_sched_pkg.sv
// Shared definitions for the byte-serial CLA scheduler: FSM states, slice width
// and a constant-width helper.
package cla_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla8_share_sched_arb.sv
// Combinational round-robin arbiter: first valid requester at or above the
// pointer, wrapping, reported both one-hot and as an index.
module rr_arb_nreq #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int             j;
  logic [IDW-1:0] jj;

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr_i) + off;
      if (j >= NREQ) j = j - NREQ;
      jj = j[IDW-1:0];
      if (valid_i[jj]) begin
        idx_o = jj;
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/cla_8.sv
// 8-bit carry-lookahead adder slice with group generate/propagate outputs.
module CLA_8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout,
  output logic       Gm,
  output logic       Pm
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       gm_acc;

  assign g = A & B;
  assign p = A ^ B;

  always_comb begin
    c      = '0;
    gm_acc = 1'b0;
    c[0]   = Cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      gm_acc = g[i] | (p[i] & gm_acc);
    end
  end

  assign S    = p ^ c[7:0];
  assign Cout = c[8];
  assign Gm   = gm_acc;
  assign Pm   = &p;

endmodule

// File: rtl/cla8_share_sched.sv
// Shares one CLA_8 slice among NREQ requesters, running each wide add/sub
// byte-serially. Subtract support is enabled by defining CLA_SCHED_SUB_EN.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1;
// req_ready is only ever raised in IDLE, and rsp_valid is held with stable
// rsp_id/rsp_sum/rsp_cout until rsp_ready is seen.
module cla8_share_sched
  import cla_sched_pkg::*;
#(
  parameter int  NREQ   = 4,
  parameter int  NBYTES = 4,
  localparam int W      = BYTE_W * NBYTES,
  localparam int IDW    = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam int             CW     = (NBYTES > 1) ? clog2(NBYTES) : 1;
  localparam logic [CW-1:0]  K_LAST = CW'(NBYTES - 1);
  localparam logic [IDW-1:0] ID_TOP = IDW'(NREQ - 1);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sub_q, sub_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   sum_q, sum_d;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;

  logic [7:0] slice_a, slice_b, slice_s;
  logic       slice_cin, slice_cout;
  logic       slice_gm_unused, slice_pm_unused;

`ifndef CLA_SCHED_SUB_EN
  logic req_sub_unused;
  assign req_sub_unused = ^req_sub;
`endif

  rr_arb_nreq #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  // Inverted B with carry-in 1 on byte 0 gives two's-complement subtract.
  assign slice_a   = a_q[k_q*BYTE_W +: BYTE_W];
  assign slice_b   = b_q[k_q*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_q}};
  assign slice_cin = (k_q == '0) ? sub_q : carry_q;

  CLA_8 u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (slice_cin),
    .S    (slice_s),
    .Cout (slice_cout),
    .Gm   (slice_gm_unused),
    .Pm   (slice_pm_unused)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    id_d    = id_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          a_d   = req_a[grant_idx*W +: W];
          b_d   = req_b[grant_idx*W +: W];
`ifdef CLA_SCHED_SUB_EN
          sub_d = req_sub[grant_idx];
`else
          sub_d = 1'b0;
`endif
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_TOP) ? '0 : grant_idx + 1'b1;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[k_q*BYTE_W +: BYTE_W] = slice_s;
        carry_d = slice_cout;
        if (k_q == K_LAST) state_d = RESP;
        else k_d = k_q + 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
    end
  end

  // rst_n gates ready so no transfer is offered while reset is held.
  assign req_ready   = (state_q == IDLE && rst_n) ? grant_oh : '0;
  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_id      = id_q;
  assign rsp_sum     = sum_q;
  assign rsp_cout    = carry_q;
  assign dbg_state_o = state_q;

endmodule
